// File: rtl/sr_latch_driver_pkg.sv
// Shared types and helpers for the SR latch driver: FSM state encoding,
// feedback synchronizer depth and the counter width helper.
package sr_latch_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        CHECK = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int SYNC_STAGES = 2;

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        int w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/status bundle between a requester (master) and the SR latch
// driver (slave).
interface sr_latch_driver_if;
    logic req_valid;
    logic req_value;
    logic req_ready;
    logic done;
    logic err;
    logic known_q;
    logic known_vld;

    modport master (
        output req_valid, req_value,
        input  req_ready, done, err, known_q, known_vld
    );

    modport slave (
        input  req_valid, req_value,
        output req_ready, done, err, known_q, known_vld
    );
endinterface

// File: rtl/sr_latch_driver_fb_sync.sv
// Multi-flop synchronizer bringing the asynchronous latch Q/Q_bar readback
// into the clk domain. Both chains clear to 0 on rst.
module sr_fb_sync
    import sr_latch_drv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic q_fb,
    input  logic qb_fb,
    output logic sync_q,
    output logic sync_qb
);

    logic [SYNC_STAGES-1:0] q_sync_q;
    logic [SYNC_STAGES-1:0] q_sync_d;
    logic [SYNC_STAGES-1:0] qb_sync_q;
    logic [SYNC_STAGES-1:0] qb_sync_d;

    // Shift the raw feedback one stage deeper each cycle.
    always_comb begin
        q_sync_d  = {q_sync_q[SYNC_STAGES-2:0], q_fb};
        qb_sync_d = {qb_sync_q[SYNC_STAGES-2:0], qb_fb};
    end

    // Synchronizer flops with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_sync_q  <= {SYNC_STAGES{1'b0}};
            qb_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            q_sync_q  <= q_sync_d;
            qb_sync_q <= qb_sync_d;
        end
    end

    assign sync_q  = q_sync_q[SYNC_STAGES-1];
    assign sync_qb = qb_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sr_latch_driver.sv
// SR latch driver: accepts a valid/ready write, issues one timed active-low
// set or reset pulse to an external NAND latch, confirms it from synchronized
// Q/Q_bar readback, inserts dead time and reports done/err.
// Optional macro SR_LATCH_DRIVER_SKIP_REDUNDANT_EN: skip the pulse when the
// latch is already known and observed to hold the requested value.
module sr_latch_driver
    import sr_latch_drv_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int GAP_CYC     = 1
)
(
    input  logic               clk,
    input  logic               rst,
    sr_latch_driver_if.slave   bus,
    output logic               s_n,
    output logic               r_n,
    input  logic               q_fb,
    input  logic               qb_fb
);

    localparam int PW = cnt_width(PULSE_CYC);
    localparam int TW = cnt_width(TIMEOUT_CYC);
    localparam int GW = cnt_width(GAP_CYC);

    state_e        state_q, state_d;
    logic          value_q, value_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          s_n_q, s_n_d;
    logic          r_n_q, r_n_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          known_q_q, known_q_d;
    logic          known_vld_q, known_vld_d;
    logic          req_ready_q, req_ready_d;
    logic          skip_q, skip_d;

    logic          sync_q_s;
    logic          sync_qb_s;
    logic          accept_s;
    logic          match_s;
    logic          skip_ok_s;

    sr_fb_sync u_fb_sync (
        .clk     (clk),
        .rst     (rst),
        .q_fb    (q_fb),
        .qb_fb   (qb_fb),
        .sync_q  (sync_q_s),
        .sync_qb (sync_qb_s)
    );

    // Decide whether an incoming request is already satisfied by the latch.
    always_comb begin
        skip_ok_s = 1'b0;
`ifdef SR_LATCH_DRIVER_SKIP_REDUNDANT_EN
        if (known_vld_q && (bus.req_value == known_q_q) &&
            (sync_q_s == bus.req_value) && (sync_qb_s == ~bus.req_value)) begin
            skip_ok_s = 1'b1;
        end else begin
            skip_ok_s = 1'b0;
        end
`endif
    end

    assign accept_s = bus.req_valid & req_ready_q;
    // Forbidden feedback (both equal) can never satisfy this.
    assign match_s  = (sync_q_s == value_q) && (sync_qb_s == ~value_q);

    // Next-state and registered-output logic of the write sequencer.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        pulse_cnt_d = {PW{1'b0}};
        tmo_cnt_d   = {TW{1'b0}};
        gap_cnt_d   = {GW{1'b0}};
        s_n_d       = 1'b1;
        r_n_d       = 1'b1;
        done_d      = 1'b0;
        err_d       = err_q;
        known_q_d   = known_q_q;
        known_vld_d = known_vld_q;
        skip_d      = 1'b0;
        req_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (skip_q) begin
                    done_d = 1'b1;
                end else if (accept_s) begin
                    value_d = bus.req_value;
                    err_d   = 1'b0;
                    if (skip_ok_s) begin
                        skip_d = 1'b1;
                    end else begin
                        state_d = PULSE;
                        s_n_d   = ~bus.req_value;
                        r_n_d   = bus.req_value;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE: begin
                if (pulse_cnt_q == PW'(PULSE_CYC - 1)) begin
                    state_d = CHECK;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                    s_n_d       = ~value_q;
                    r_n_d       = value_q;
                end
            end
            CHECK: begin
                if (match_s || (tmo_cnt_q == TW'(TIMEOUT_CYC - 1))) begin
                    if (match_s) begin
                        known_q_d   = value_q;
                        known_vld_d = 1'b1;
                    end else begin
                        err_d       = 1'b1;
                        known_vld_d = 1'b0;
                    end
                    if (GAP_CYC == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE) && !skip_d;
    end

    // Sequencer state and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            value_q     <= 1'b0;
            pulse_cnt_q <= {PW{1'b0}};
            tmo_cnt_q   <= {TW{1'b0}};
            gap_cnt_q   <= {GW{1'b0}};
            s_n_q       <= 1'b1;
            r_n_q       <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            known_q_q   <= 1'b0;
            known_vld_q <= 1'b0;
            req_ready_q <= 1'b1;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            pulse_cnt_q <= pulse_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            s_n_q       <= s_n_d;
            r_n_q       <= r_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
            known_q_q   <= known_q_d;
            known_vld_q <= known_vld_d;
            req_ready_q <= req_ready_d;
            skip_q      <= skip_d;
        end
    end

    assign s_n           = s_n_q;
    assign r_n           = r_n_q;
    assign bus.req_ready = req_ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.known_q   = known_q_q;
    assign bus.known_vld = known_vld_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural NAND SR latch model.
// Inputs change and outputs are sampled on the falling clock edge; cycle tK
// is the K-th falling edge after the one where a request is raised (t0).
module tb_sr_latch_driver;
    import sr_latch_drv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_n, r_n, q_fb, qb_fb;
    logic latch_q = 1'b0;
    logic stuck = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   overlap_err = 0;

    sr_latch_driver_if bus();

    sr_latch_driver #(.PULSE_CYC(4), .TIMEOUT_CYC(16), .GAP_CYC(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .s_n   (s_n),
        .r_n   (r_n),
        .q_fb  (q_fb),
        .qb_fb (qb_fb)
    );

    always #5 clk = ~clk;

    // NAND latch: low S_n sets, low R_n resets, both high holds.
    always @(s_n or r_n) begin
        if (s_n === 1'b0) latch_q = 1'b1;
        else if (r_n === 1'b0) latch_q = 1'b0;
    end

    assign q_fb  = stuck ? 1'b0 : latch_q;
    assign qb_fb = stuck ? 1'b1 : ~latch_q;

    // Both latch inputs low at once is never allowed.
    always @(negedge clk) begin
        if (s_n === 1'b0 && r_n === 1'b0) begin
            overlap_err++;
            $display("FAIL overlap s_n=%b r_n=%b at %0t", s_n, r_n, $time);
        end
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_n !== 1'b1)  begin errors++; $display("FAIL rst_s_n got %b exp 1", s_n); end
        checks++; if (r_n !== 1'b1)  begin errors++; $display("FAIL rst_r_n got %b exp 1", r_n); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
        checks++; if (bus.err !== 1'b0)  begin errors++; $display("FAIL rst_err got %b exp 0", bus.err); end
        checks++; if (bus.known_q !== 1'b0) begin errors++; $display("FAIL rst_known_q got %b exp 0", bus.known_q); end
        checks++; if (bus.known_vld !== 1'b0) begin errors++; $display("FAIL rst_known_vld got %b exp 0", bus.known_vld); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp IDLE", dut.state_q); end
    endtask

    task automatic test_set();
        logic exp_s;
        bus.req_valid = 1'b1;
        bus.req_value = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            exp_s = (k <= 4) ? 1'b0 : 1'b1;
            checks++; if (s_n !== exp_s) begin errors++; $display("FAIL set_s_n t%0d got %b exp %b", k, s_n, exp_s); end
            checks++; if (r_n !== 1'b1) begin errors++; $display("FAIL set_r_n t%0d got %b exp 1", k, r_n); end
            checks++; if (bus.done !== (k == 7)) begin errors++; $display("FAIL set_done t%0d got %b exp %b", k, bus.done, (k == 7)); end
        end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL set_err got %b exp 0", bus.err); end
        checks++; if (bus.known_q !== 1'b1) begin errors++; $display("FAIL set_known_q got %b exp 1", bus.known_q); end
        checks++; if (bus.known_vld !== 1'b1) begin errors++; $display("FAIL set_known_vld got %b exp 1", bus.known_vld); end
        checks++; if (latch_q !== 1'b1) begin errors++; $display("FAIL set_latch got %b exp 1", latch_q); end
    endtask

    task automatic test_reset_write();
        logic exp_r;
        bus.req_valid = 1'b1;
        bus.req_value = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            exp_r = (k <= 4) ? 1'b0 : 1'b1;
            checks++; if (r_n !== exp_r) begin errors++; $display("FAIL rw_r_n t%0d got %b exp %b", k, r_n, exp_r); end
            checks++; if (s_n !== 1'b1) begin errors++; $display("FAIL rw_s_n t%0d got %b exp 1", k, s_n); end
            checks++; if (bus.done !== (k == 7)) begin errors++; $display("FAIL rw_done t%0d got %b exp %b", k, bus.done, (k == 7)); end
        end
        checks++; if (bus.known_q !== 1'b0) begin errors++; $display("FAIL rw_known_q got %b exp 0", bus.known_q); end
        checks++; if (bus.known_vld !== 1'b1) begin errors++; $display("FAIL rw_known_vld got %b exp 1", bus.known_vld); end
        checks++; if (q_fb !== 1'b0 || qb_fb !== 1'b1) begin errors++; $display("FAIL rw_latch got q=%b qb=%b exp q=0 qb=1", q_fb, qb_fb); end
    endtask

    task automatic test_stuck();
        logic exp_s;
        stuck = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_value = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            exp_s = (k <= 4) ? 1'b0 : 1'b1;
            checks++; if (s_n !== exp_s) begin errors++; $display("FAIL stuck_s_n t%0d got %b exp %b", k, s_n, exp_s); end
            checks++; if (bus.done !== (k == 22)) begin errors++; $display("FAIL stuck_done t%0d got %b exp %b", k, bus.done, (k == 22)); end
        end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL stuck_err got %b exp 1", bus.err); end
        checks++; if (bus.known_vld !== 1'b0) begin errors++; $display("FAIL stuck_known_vld got %b exp 0", bus.known_vld); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL stuck_ready got %b exp 1", bus.req_ready); end
        stuck = 1'b0;
        @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL stuck_err_hold got %b exp 1", bus.err); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL stuck_done_once got %b exp 0", bus.done); end
        bus.req_valid = 1'b1;
        bus.req_value = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (k == 1) begin
                checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL stuck_err_clear got %b exp 0", bus.err); end
            end
            checks++; if (bus.done !== (k == 7)) begin errors++; $display("FAIL stuck_rec_done t%0d got %b exp %b", k, bus.done, (k == 7)); end
        end
        checks++; if (bus.known_vld !== 1'b1) begin errors++; $display("FAIL stuck_rec_vld got %b exp 1", bus.known_vld); end
    endtask

    task automatic test_rst_mid();
        bus.req_valid = 1'b1;
        bus.req_value = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (k <= 2) begin
                checks++; if (r_n !== 1'b0) begin errors++; $display("FAIL mid_r_n t%0d got %b exp 0", k, r_n); end
            end
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                checks++; if (r_n !== 1'b1 || s_n !== 1'b1) begin errors++; $display("FAIL mid_abort got s_n=%b r_n=%b exp 1 1", s_n, r_n); end
                rst = 1'b0;
            end
            if (k == 4) begin
                checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", bus.req_ready); end
                checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_state got %0d exp IDLE", dut.state_q); end
                checks++; if (bus.known_vld !== 1'b0) begin errors++; $display("FAIL mid_known_vld got %b exp 0", bus.known_vld); end
            end
            if (k >= 3) begin
                checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_done t%0d got %b exp 0", k, bus.done); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.req_valid = 1'b1;
        bus.req_value = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (s_n !== 1'b0) begin errors++; $display("FAIL b2b_s_n1 got %b exp 0", s_n); end
            end
            if (k < 7 || (k > 7 && k < 14)) begin
                checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done t%0d got %b exp 0", k, bus.done); end
            end
            if (k == 7) begin
                checks++; if (bus.done !== 1'b1 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_done1 got done=%b ready=%b exp 1 1", bus.done, bus.req_ready); end
                checks++; if (bus.known_q !== 1'b1) begin errors++; $display("FAIL b2b_known1 got %b exp 1", bus.known_q); end
                bus.req_value = 1'b0;
            end
            if (k == 8) begin
                checks++; if (r_n !== 1'b0 || s_n !== 1'b1) begin errors++; $display("FAIL b2b_pulse2 got s_n=%b r_n=%b exp 1 0", s_n, r_n); end
                checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready2 got %b exp 0", bus.req_ready); end
            end
            if (k == 14) begin
                checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", bus.done); end
                checks++; if (bus.known_q !== 1'b0) begin errors++; $display("FAIL b2b_known2 got %b exp 0", bus.known_q); end
                bus.req_valid = 1'b0;
            end
            if (k == 15) begin
                checks++; if (bus.req_ready !== 1'b1 || s_n !== 1'b1 || r_n !== 1'b1 || bus.done !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle got ready=%b s_n=%b r_n=%b done=%b exp 1 1 1 0", bus.req_ready, s_n, r_n, bus.done);
                end
            end
        end
    endtask

    task automatic test_redundant();
        bus.req_valid = 1'b1;
        bus.req_value = 1'b0;
`ifdef SR_LATCH_DRIVER_SKIP_REDUNDANT_EN
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            checks++; if (s_n !== 1'b1 || r_n !== 1'b1) begin errors++; $display("FAIL skip_pins t%0d got s_n=%b r_n=%b exp 1 1", k, s_n, r_n); end
            checks++; if (bus.done !== (k == 2)) begin errors++; $display("FAIL skip_done t%0d got %b exp %b", k, bus.done, (k == 2)); end
            checks++; if (bus.req_ready !== (k == 2)) begin errors++; $display("FAIL skip_ready t%0d got %b exp %b", k, bus.req_ready, (k == 2)); end
        end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL skip_err got %b exp 0", bus.err); end
        checks++; if (bus.known_q !== 1'b0 || bus.known_vld !== 1'b1) begin errors++; $display("FAIL skip_known got %b/%b exp 0/1", bus.known_q, bus.known_vld); end
`else
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (k == 1) begin
                checks++; if (r_n !== 1'b0) begin errors++; $display("FAIL rep_r_n got %b exp 0", r_n); end
            end
            checks++; if (bus.done !== (k == 7)) begin errors++; $display("FAIL rep_done t%0d got %b exp %b", k, bus.done, (k == 7)); end
        end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rep_err got %b exp 0", bus.err); end
        checks++; if (bus.known_q !== 1'b0 || bus.known_vld !== 1'b1) begin errors++; $display("FAIL rep_known got %b/%b exp 0/1", bus.known_q, bus.known_vld); end
`endif
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_value = 1'b0;
        test_reset();
        test_set();
        test_reset_write();
        test_stuck();
        test_rst_mid();
        test_back_to_back();
        test_redundant();
        repeat (2) @(negedge clk);
        checks++;
        if (overlap_err !== 0) begin
            errors++;
            $display("FAIL overlap_count got %0d exp 0", overlap_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
